// File: rtl/rn_pkg.sv
// Shared types and helpers for the rename-stage pipeline controller.
package rn_pkg;
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    WALK  = 2'd2
  } rn_state_e;

  localparam int ROB_DEPTH_DEF  = 32;
  localparam int FREE_PREGS_DEF = 32;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction
endpackage

// File: rtl/rn_credit_ctr.sv
// Saturating credit counter: returns from commit/walk, consumption on rename fire.
module rn_credit_ctr #(
  parameter int CW   = 6,
  parameter int MAXV = 32,
  parameter int RSTV = MAXV
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    commit_cnt,
  input  logic [2:0]    walk_cnt,
  input  logic [2:0]    take_cnt,
  output logic [CW-1:0] credit
);
  localparam int W = CW + 1;

  logic [CW-1:0] credit_q, credit_d;
  logic [W-1:0]  sum;

  always_comb begin
    sum      = {1'b0, credit_q} + W'(commit_cnt) + W'(walk_cnt) - W'(take_cnt);
    credit_d = (sum > W'(MAXV)) ? CW'(MAXV) : sum[CW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) credit_q <= CW'(RSTV);
    else     credit_q <= credit_d;
  end

`ifndef SYNTHESIS
  // Returns beyond the pool size mean a producer double-counted an entry.
  always @(posedge clk) begin
    if (!rst) assert (sum <= W'(MAXV)) else $error("rn_credit_ctr: credit overflow clamped");
  end
`endif

  assign credit = credit_q;
endmodule

// File: rtl/rn_pipe_ctrl.sv
// Rename-stage stall/flush controller with ROB and physical-register credits.
// Optional RN_STALL_PERF_EN adds stall and recovery cycle counters.
module rn_pipe_ctrl
  import rn_pkg::*;
#(
  parameter int ROB_DEPTH  = ROB_DEPTH_DEF,
  parameter int FREE_PREGS = FREE_PREGS_DEF,
  parameter int CW         = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    RN_Instvalid,
  input  logic [3:0]    RN_RegW,
  input  logic          iq_full,
  input  logic [2:0]    commit_rob_cnt,
  input  logic [2:0]    commit_preg_cnt,
  input  logic          mispredict,
  input  logic [2:0]    walk_rob_cnt,
  input  logic [2:0]    walk_preg_cnt,
  input  logic          walk_done,
  output logic          stall,
  output logic          flush,
  output logic          rn_fire,
  output logic [CW-1:0] rob_credit,
  output logic [CW-1:0] preg_credit
`ifdef RN_STALL_PERF_EN
  ,
  output logic [31:0]   perf_stall_cyc,
  output logic [31:0]   perf_recover_cyc
`endif
);
  rn_state_e  state_q, state_d;
  logic [2:0] need_rob, need_preg;
  logic [2:0] take_rob, take_preg;

  assign need_rob  = popcount4(RN_Instvalid);
  assign need_preg = popcount4(RN_Instvalid & RN_RegW);

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    flush   = 1'b0;
    case (state_q)
      RUN: begin
        // Mispredict wins: the bundle is being flushed, so holding it is pointless.
        stall = !mispredict & (iq_full | (CW'(need_rob) > rob_credit) |
                               (CW'(need_preg) > preg_credit));
        flush = mispredict;
        if (mispredict) state_d = FLUSH;
      end
      FLUSH: begin
        stall   = 1'b1;
        flush   = 1'b1;
        state_d = mispredict ? FLUSH : WALK;
      end
      WALK: begin
        stall = 1'b1;
        flush = mispredict;
        if (mispredict)     state_d = FLUSH;
        else if (walk_done) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign rn_fire   = (state_q == RUN) & (|RN_Instvalid) & !stall & !mispredict;
  assign take_rob  = rn_fire ? need_rob  : 3'd0;
  assign take_preg = rn_fire ? need_preg : 3'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  rn_credit_ctr #(.CW(CW), .MAXV(ROB_DEPTH), .RSTV(ROB_DEPTH)) u_rob_ctr (
    .clk        (clk),
    .rst        (rst),
    .commit_cnt (commit_rob_cnt),
    .walk_cnt   (walk_rob_cnt),
    .take_cnt   (take_rob),
    .credit     (rob_credit)
  );

  rn_credit_ctr #(.CW(CW), .MAXV(FREE_PREGS), .RSTV(FREE_PREGS)) u_preg_ctr (
    .clk        (clk),
    .rst        (rst),
    .commit_cnt (commit_preg_cnt),
    .walk_cnt   (walk_preg_cnt),
    .take_cnt   (take_preg),
    .credit     (preg_credit)
  );

`ifdef RN_STALL_PERF_EN
  logic [31:0] stall_cyc_q, recover_cyc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cyc_q   <= '0;
      recover_cyc_q <= '0;
    end else begin
      if (state_q == RUN && stall) stall_cyc_q   <= stall_cyc_q + 32'd1;
      if (state_q != RUN)          recover_cyc_q <= recover_cyc_q + 32'd1;
    end
  end

  assign perf_stall_cyc   = stall_cyc_q;
  assign perf_recover_cyc = recover_cyc_q;
`endif
endmodule

// File: tb/tb_rn_pipe_ctrl.sv
// Self-checking bench for rn_pipe_ctrl: directed vector table, corner sequences, random vs model.
module tb_rn_pipe_ctrl;
  localparam int CW = 6;
  localparam int RD = 32;
  localparam int FP = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    RN_Instvalid, RN_RegW;
  logic          iq_full, mispredict, walk_done;
  logic [2:0]    commit_rob_cnt, commit_preg_cnt, walk_rob_cnt, walk_preg_cnt;
  logic          stall, flush, rn_fire;
  logic [CW-1:0] rob_credit, preg_credit;
`ifdef RN_STALL_PERF_EN
  logic [31:0]   perf_stall_cyc, perf_recover_cyc;
`endif

  rn_pipe_ctrl #(.ROB_DEPTH(RD), .FREE_PREGS(FP), .CW(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .RN_Instvalid    (RN_Instvalid),
    .RN_RegW         (RN_RegW),
    .iq_full         (iq_full),
    .commit_rob_cnt  (commit_rob_cnt),
    .commit_preg_cnt (commit_preg_cnt),
    .mispredict      (mispredict),
    .walk_rob_cnt    (walk_rob_cnt),
    .walk_preg_cnt   (walk_preg_cnt),
    .walk_done       (walk_done),
    .stall           (stall),
    .flush           (flush),
    .rn_fire         (rn_fire),
    .rob_credit      (rob_credit),
    .preg_credit     (preg_credit)
`ifdef RN_STALL_PERF_EN
    ,
    .perf_stall_cyc  (perf_stall_cyc),
    .perf_recover_cyc(perf_recover_cyc)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] w, input logic iq,
                       input logic [2:0] cr, input logic [2:0] cp, input logic mp,
                       input logic [2:0] wr, input logic [2:0] wp, input logic wd);
    RN_Instvalid = v; RN_RegW = w; iq_full = iq;
    commit_rob_cnt = cr; commit_preg_cnt = cp; mispredict = mp;
    walk_rob_cnt = wr; walk_preg_cnt = wp; walk_done = wd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic [3:0] v, w;
    logic       iq;
    logic [2:0] cr, cp;
    logic       mp;
    logic [2:0] wr, wp;
    logic       wd;
    logic       st, fl, fi;
    int         rc, pc;
  } vec_t;

  vec_t tbl[28];

  function automatic vec_t mk(logic [3:0] v, logic [3:0] w, logic iq, logic [2:0] cr,
                              logic [2:0] cp, logic mp, logic [2:0] wr, logic [2:0] wp,
                              logic wd, logic st, logic fl, logic fi, int rc, int pc);
    vec_t t;
    t.v = v; t.w = w; t.iq = iq; t.cr = cr; t.cp = cp; t.mp = mp;
    t.wr = wr; t.wp = wp; t.wd = wd; t.st = st; t.fl = fl; t.fi = fi; t.rc = rc; t.pc = pc;
    return t;
  endfunction

  // Reference model: mode 0=running, 1=flushing, 2=walking back.
  int ms, mrob, mpreg;
  logic e_st, e_fl, e_fi;

  task automatic model_eval();
    int nr, np;
    nr = $countones(RN_Instvalid);
    np = $countones(RN_Instvalid & RN_RegW);
    e_fi = 1'b0;
    if (ms == 0) begin
      e_fl = mispredict;
      e_st = !mispredict && (iq_full || nr > mrob || np > mpreg);
      e_fi = (nr > 0) && !e_st && !mispredict;
    end else begin
      e_st = 1'b1;
      e_fl = (ms == 1) || mispredict;
    end
  endtask

  task automatic model_update();
    int nr, np;
    nr = e_fi ? $countones(RN_Instvalid) : 0;
    np = e_fi ? $countones(RN_Instvalid & RN_RegW) : 0;
    mrob  = mrob  + commit_rob_cnt  + walk_rob_cnt  - nr;
    mpreg = mpreg + commit_preg_cnt + walk_preg_cnt - np;
    if (mrob > RD)  mrob  = RD;
    if (mpreg > FP) mpreg = FP;
    if (mispredict)                  ms = 1;
    else if (ms == 1)                ms = 2;
    else if (ms == 2 && walk_done)   ms = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    #2;
    chk("rst_stall", stall, 0);
    chk("rst_flush", flush, 0);
    chk("rst_fire",  rn_fire, 0);
    chk("rst_rob",   rob_credit, RD);
    chk("rst_preg",  preg_credit, FP);
`ifdef RN_STALL_PERF_EN
    chk("rst_perf_stall", perf_stall_cyc, 0);
    chk("rst_perf_rec",   perf_recover_cyc, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    ms = 0; mrob = RD; mpreg = FP;
  endtask

  initial begin
    // Full bundles drain 32/32 credits in 8 cycles, then stall.
    for (int i = 0; i < 8; i++)
      tbl[i] = mk(4'hf, 4'hf, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32 - 4*i, 32 - 4*i);
    tbl[8]  = mk(4'hf, 4'hf, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    tbl[9]  = mk(4'h0, 4'h0, 0, 2, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Short by one ROB entry; the same-cycle commit is not forwarded.
    tbl[10] = mk(4'h7, 4'h0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 2, 4);
    tbl[11] = mk(4'h7, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 4);
    tbl[12] = mk(4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4);
    tbl[13] = mk(4'h0, 4'h0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 4);
    // Mispredict, flush, three walk cycles of 4 credits, walk_done.
    tbl[14] = mk(4'h0, 4'h0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 4);
    tbl[15] = mk(4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 4);
    tbl[16] = mk(4'h0, 4'h0, 0, 0, 0, 0, 4, 4, 0, 1, 0, 0, 0, 4);
    tbl[17] = mk(4'h0, 4'h0, 0, 0, 0, 0, 4, 4, 0, 1, 0, 0, 4, 8);
    tbl[18] = mk(4'h0, 4'h0, 0, 0, 0, 0, 4, 4, 0, 1, 0, 0, 8, 12);
    tbl[19] = mk(4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 12, 16);
    tbl[20] = mk(4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12, 16);
    // Mispredict during walk restarts the flush; walk_done alongside is ignored.
    tbl[21] = mk(4'h0, 4'h0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 12, 16);
    tbl[22] = mk(4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 12, 16);
    tbl[23] = mk(4'h0, 4'h0, 0, 0, 0, 1, 0, 0, 1, 1, 1, 0, 12, 16);
    tbl[24] = mk(4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 12, 16);
    tbl[25] = mk(4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 12, 16);
    tbl[26] = mk(4'hf, 4'h1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 12, 16);
    tbl[27] = mk(4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8, 15);

    do_reset();
    for (int i = 0; i < 28; i++) begin
      drive(tbl[i].v, tbl[i].w, tbl[i].iq, tbl[i].cr, tbl[i].cp, tbl[i].mp,
            tbl[i].wr, tbl[i].wp, tbl[i].wd);
      #2;
      chk($sformatf("v%0d_stall", i), stall,       tbl[i].st);
      chk($sformatf("v%0d_flush", i), flush,       tbl[i].fl);
      chk($sformatf("v%0d_fire",  i), rn_fire,     tbl[i].fi);
      chk($sformatf("v%0d_rob",   i), rob_credit,  tbl[i].rc);
      chk($sformatf("v%0d_preg",  i), preg_credit, tbl[i].pc);
      next_cycle();
    end

    // Asynchronous reset mid-walk aborts recovery at once.
    drive(4'h0, 4'h0, 0, 0, 0, 1, 0, 0, 0); next_cycle();
    drive(4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 0); next_cycle();
    drive(4'h0, 4'h0, 0, 0, 0, 0, 4, 4, 0); next_cycle();
    drive(4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("walk_pre_rst_stall", stall, 1);
    #1 rst = 1'b1;
    #1;
    chk("arst_stall", stall, 0);
    chk("arst_flush", flush, 0);
    chk("arst_rob",   rob_credit, RD);
    chk("arst_preg",  preg_credit, FP);
    @(negedge clk);
    rst = 1'b0;

`ifdef RN_STALL_PERF_EN
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(4'h0, 4'h0, 1, 0, 0, 0, 0, 0, 0); next_cycle();
    end
    drive(4'h0, 4'h0, 0, 0, 0, 1, 0, 0, 0); next_cycle();
    drive(4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 0); next_cycle();
    next_cycle();
    next_cycle();
    drive(4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 1); next_cycle();
    drive(4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 0); next_cycle();
    #2;
    chk("perf_stall_cyc",   perf_stall_cyc,   5);
    chk("perf_recover_cyc", perf_recover_cyc, 4);
`endif

    // Random traffic against the model; returns never exceed what is outstanding.
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      int room_r, room_p, wr, wp, cr, cp;
      room_r = RD - mrob;
      room_p = FP - mpreg;
      wr = (ms == 2) ? $urandom_range((room_r < 4) ? room_r : 4, 0) : 0;
      wp = (ms == 2) ? $urandom_range((room_p < 4) ? room_p : 4, 0) : 0;
      cr = $urandom_range((room_r - wr < 4) ? room_r - wr : 4, 0);
      cp = $urandom_range((room_p - wp < 4) ? room_p - wp : 4, 0);
      drive(4'($urandom), 4'($urandom), ($urandom_range(7, 0) == 0),
            3'(cr), 3'(cp), ($urandom_range(24, 0) == 0),
            3'(wr), 3'(wp), (ms == 2) && ($urandom_range(3, 0) == 0));
      #2;
      model_eval();
      chk("rnd_stall", stall,       e_st);
      chk("rnd_flush", flush,       e_fl);
      chk("rnd_fire",  rn_fire,     e_fi);
      chk("rnd_rob",   rob_credit,  mrob);
      chk("rnd_preg",  preg_credit, mpreg);
      @(posedge clk);
      model_update();
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rn_pipe_ctrl.md
RN_PIPE_CTRL -- requirements
Module: rn_pipe_ctrl

Interface
REQ-001 Parameter ROB_DEPTH, default 32: ROB entries available to rename.
REQ-002 Parameter FREE_PREGS, default 32: physical registers on the free list after reset.
REQ-003 Parameter CW, default 6: credit counter width; must satisfy 2^CW > max(ROB_DEPTH, FREE_PREGS).
REQ-004 clk  in  1  clock; all state updates on posedge; one clock, asynchronous active-high reset.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 RN_Instvalid  in  4  per-slot valid bits of the 4-wide rename-stage bundle.
REQ-007 RN_RegW  in  4  per-slot destination-write bits of the rename-stage bundle.
REQ-008 iq_full  in  1  issue queue cannot accept a bundle this cycle.
REQ-009 commit_rob_cnt  in  3  ROB entries retired this cycle (0..4).
REQ-010 commit_preg_cnt  in  3  physical registers freed by retirement this cycle (0..4).
REQ-011 mispredict  in  1  branch-mispredict pulse from execute.
REQ-012 walk_rob_cnt  in  3  squashed ROB entries returned this cycle during walk-back (0..4).
REQ-013 walk_preg_cnt  in  3  squashed physical registers returned this cycle during walk-back (0..4).
REQ-014 walk_done  in  1  ROB walk-back complete.
REQ-015 stall  out  1  hold the decode-to-rename register and all upstream stages.
REQ-016 flush  out  1  clear the decode-to-rename register and upstream stages.
REQ-017 rn_fire  out  1  rename bundle accepted this cycle.
REQ-018 rob_credit  out  CW  registered count of free ROB entries.
REQ-019 preg_credit  out  CW  registered count of free physical registers.

Function
REQ-020 FSM states are RUN, FLUSH and WALK; reset state is RUN.
REQ-021 need_rob is popcount(RN_Instvalid); need_preg is popcount(RN_Instvalid & RN_RegW).
REQ-022 In RUN, stall = iq_full | (need_rob > rob_credit) | (need_preg > preg_credit); comparisons use registered credits only (same-cycle commits are not forwarded).
REQ-023 rn_fire = (state==RUN) & |RN_Instvalid & !stall & !mispredict.
REQ-024 Each cycle: rob_credit_next = rob_credit + commit_rob_cnt + walk_rob_cnt - (rn_fire ? need_rob : 0); preg_credit updates likewise with the preg counts; all arithmetic is done at CW+1 bits.
REQ-025 A credit result above ROB_DEPTH or FREE_PREGS clamps to that maximum and raises a simulation-only error.
REQ-026 mispredict in RUN: same cycle, flush=1, stall=0 and rn_fire=0; next state is FLUSH.
REQ-027 FLUSH lasts exactly one cycle with flush=1 and stall=1, then goes to WALK.
REQ-028 WALK: stall=1 and flush=0; walk counts and commit counts both credit; walk_done moves to RUN on the next cycle.
REQ-029 mispredict in FLUSH or WALK returns to FLUSH, with flush=1 in that cycle; walk_done in the same cycle is ignored.
REQ-030 walk_*_cnt inputs are honored in every state; the producer drives them nonzero only in WALK.
REQ-031 Empty bundle in RUN: no stall from credits; stall = iq_full only.
REQ-032 Outputs stall, flush and rn_fire are combinational from the FSM state, the credits and the inputs; there are no combinational paths from walk_* to outputs.

Reset
REQ-033 On rst: state=RUN, rob_credit=ROB_DEPTH, preg_credit=FREE_PREGS, and performance counters (if compiled in) are 0.
REQ-034 rst asserted mid-FLUSH or mid-WALK aborts recovery immediately; stall and flush drop to 0 while reset is held (given RN_Instvalid=0 and iq_full=0).

Configuration
REQ-035 With macro RN_STALL_PERF_EN defined, 32-bit outputs perf_stall_cyc (RUN cycles with stall=1) and perf_recover_cyc (cycles in FLUSH or WALK) are added; both wrap at 2^32.
REQ-036 Without RN_STALL_PERF_EN, those ports and their counters are absent, and behaviour is otherwise identical.

Structure
REQ-037 Shared package rn_pkg holds the FSM state enum, the ROB_DEPTH and FREE_PREGS defaults, and the popcount4 function.
REQ-038 One sub-module, rn_credit_ctr, is instantiated twice (ROB, preg): it does saturating add/subtract with the reset value as a parameter.

Verification
REQ-039 Reset, then bundle valid=4'b1111 with RegW=4'b1111 for 8 cycles, no commits: rn_fire for 8 cycles, rob_credit=0 and preg_credit=0; 9th bundle stall=1.
REQ-040 rob_credit=2, bundle valid=4'b0111: stall=1; commit_rob_cnt=1 -> stall still 1 that cycle, stall=0 and rn_fire=1 the next cycle, rob_credit goes 3->0.
REQ-041 mispredict pulse in RUN: flush=1 that cycle and the next (FLUSH), then stall=1 in WALK; walk_rob_cnt=4 for 3 cycles adds 12 credits; walk_done -> RUN one cycle later.
REQ-042 mispredict during WALK: flush=1 that cycle and re-enter FLUSH; walk_done in the same cycle is ignored.
REQ-043 rst pulse during WALK: state=RUN, credits=32/32, stall=0 immediately.
REQ-044 With RN_STALL_PERF_EN: 5 iq_full cycles plus one recovery of 4 cycles -> perf_stall_cyc=5, perf_recover_cyc=4.
